instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_if.sv | 29 ++
 rtl/instr_loader.sv | 141 ++++++++++++++
 tb/tb_instr_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-bank write/status bus of the instruction loader.
// The master side is the loader itself; the slave side is the byte source and bank.
interface instr_loader_if #(
  parameter int NUM_INSTR = 32
);
  localparam int AW = $clog2(NUM_INSTR);
  localparam int LW = $clog2(NUM_INSTR + 1);

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          program_valid;
  logic [LW-1:0] num_loaded;
  logic          busy;
  logic          load_done;
  logic          load_err;

  modport master (
    input  rx_valid, rx_data,
    output wr_en, wr_addr, wr_data, program_valid, num_loaded, busy, load_done, load_err
  );

  modport slave (
    output rx_valid, rx_data,
    input  wr_en, wr_addr, wr_data, program_valid, num_loaded, busy, load_done, load_err
  );
endinterface

// File: rtl/instr_loader.sv
// Frame parser that loads a checksum-verified program of 32-bit words from a byte stream.
// Frame: 0xA5, length N, 4N payload bytes (MSB first per word), XOR checksum seeded with N.
module instr_loader #(
  parameter int NUM_INSTR      = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  instr_loader_if.master bus
);
  localparam int AW = $clog2(NUM_INSTR);
  localparam int LW = $clog2(NUM_INSTR + 1);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LEN, DATA, CHECK} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] idle_cnt_reg;
  logic [LW-1:0] len_reg;
  logic [AW-1:0] word_idx_reg;
  logic [1:0]    byte_cnt_reg;
  logic [31:0]   word_reg;
  logic [7:0]    csum_reg;
  logic          wr_en_reg;
  logic [AW-1:0] wr_addr_reg;
  logic [31:0]   wr_data_reg;
  logic          pv_reg;
  logic [LW-1:0] num_loaded_reg;
  logic          done_reg;
  logic          err_reg;

  logic timeout;
  logic accept;
  logic len_ok;
  logic word_end;
  logic last_word;
  logic busy;
  logic frame_done;
  logic frame_err;

  // A timeout wins over a byte arriving on the same cycle, which is then dropped.
  assign timeout   = (state_reg != IDLE) && (idle_cnt_reg == CW'(TIMEOUT_CYCLES - 1));
  assign accept    = bus.rx_valid && !timeout;
  assign len_ok    = (bus.rx_data != 8'h00) && ({24'h0, bus.rx_data} <= 32'(NUM_INSTR));
  assign word_end  = (byte_cnt_reg == 2'd3);
  assign last_word = ((LW'(word_idx_reg) + LW'(1)) == len_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (timeout) begin
      state_next = IDLE;
    end else if (accept) begin
      case (state_reg)
        IDLE:    if (bus.rx_data == 8'hA5) state_next = LEN;
        LEN:     state_next = len_ok ? DATA : IDLE;
        DATA:    if (word_end && last_word) state_next = CHECK;
        CHECK:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_reg != IDLE);
    frame_done = accept && (state_reg == CHECK) && (bus.rx_data == csum_reg);
    frame_err  = timeout
              || (accept && (state_reg == LEN) && !len_ok)
              || (accept && (state_reg == CHECK) && (bus.rx_data != csum_reg));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt_reg   <= '0;
      len_reg        <= '0;
      word_idx_reg   <= '0;
      byte_cnt_reg   <= '0;
      word_reg       <= '0;
      csum_reg       <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      pv_reg         <= 1'b0;
      num_loaded_reg <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      wr_en_reg    <= 1'b0;
      done_reg     <= frame_done;
      err_reg      <= frame_err;
      idle_cnt_reg <= (state_next == IDLE || accept) ? '0 : idle_cnt_reg + CW'(1);
      if (accept) begin
        case (state_reg)
          IDLE: begin
            if (bus.rx_data == 8'hA5) pv_reg <= 1'b0;
          end
          LEN: begin
            len_reg      <= LW'(bus.rx_data);
            csum_reg     <= bus.rx_data;
            word_idx_reg <= '0;
            byte_cnt_reg <= '0;
          end
          DATA: begin
            csum_reg     <= csum_reg ^ bus.rx_data;
            word_reg     <= {word_reg[23:0], bus.rx_data};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (word_end) begin
              wr_en_reg    <= 1'b1;
              wr_addr_reg  <= word_idx_reg;
              wr_data_reg  <= {word_reg[23:0], bus.rx_data};
              word_idx_reg <= word_idx_reg + AW'(1);
            end
          end
          CHECK: begin
            if (bus.rx_data == csum_reg) begin
              pv_reg         <= 1'b1;
              num_loaded_reg <= len_reg;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.wr_en         = wr_en_reg;
  assign bus.wr_addr       = wr_addr_reg;
  assign bus.wr_data       = wr_data_reg;
  assign bus.program_valid = pv_reg;
  assign bus.num_loaded    = num_loaded_reg;
  assign bus.busy          = busy;
  assign bus.load_done     = done_reg;
  assign bus.load_err      = err_reg;
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: expected writes are queued as bytes are driven
// and popped by a monitor when wr_en appears; frame outcomes are checked after each step.
module tb_instr_loader;
  localparam int N  = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_loader_if #(.NUM_INSTR(N)) bus ();

  instr_loader #(.NUM_INSTR(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int done_seen = 0;
  int err_seen = 0;
  int wr_seen = 0;
  logic [36:0] exp_q[$];
  logic [31:0] words[N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pulse counting and scoreboard pop on every bank write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.load_done) done_seen++;
      if (bus.load_err) err_seen++;
      if (bus.load_done || bus.load_err)
        check("done_err_exclusive", 64'(bus.load_done & bus.load_err), 64'(0));
      if (bus.wr_en) begin
        logic [36:0] e;
        wr_seen++;
        $display("write addr=%0d data=%08h", bus.wr_addr, bus.wr_data);
        check("write_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("write_addr_data", 64'({bus.wr_addr, bus.wr_data}), 64'(e));
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
    end
  endtask

  task automatic send_frame(input int n, input bit corrupt);
    logic [7:0] cs;
    logic [7:0] nb;
    logic [7:0] b;
    logic [4:0] a;
    nb = 8'(n);
    cs = nb;
    send(8'hA5);
    send(nb);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        b  = words[w][31-8*k -: 8];
        cs = cs ^ b;
        if (k == 3) begin
          a = 5'(w);
          exp_q.push_back({a, words[w]});
        end
        send(b);
      end
    end
    send(corrupt ? (cs ^ 8'h01) : cs);
    $display("frame sent len=%0d checksum=%02h corrupt=%0d", n, cs, corrupt);
  endtask

  task automatic expect_outcome(input string tag, input int d0, input int e0, input int w0,
                                input int dd, input int de, input int dw,
                                input logic pv, input logic [5:0] nl);
    check({tag, "_done"}, 64'(done_seen - d0), 64'(dd));
    check({tag, "_err"}, 64'(err_seen - e0), 64'(de));
    check({tag, "_writes"}, 64'(wr_seen - w0), 64'(dw));
    check({tag, "_pv"}, 64'(bus.program_valid), 64'(pv));
    check({tag, "_num"}, 64'(bus.num_loaded), 64'(nl));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_queue"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 64'(bus.wr_en), 64'(0));
    check({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'(0));
    check({tag, "_wr_data"}, 64'(bus.wr_data), 64'(0));
    check({tag, "_pv"}, 64'(bus.program_valid), 64'(0));
    check({tag, "_num"}, 64'(bus.num_loaded), 64'(0));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_done"}, 64'(bus.load_done), 64'(0));
    check({tag, "_err"}, 64'(bus.load_err), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, w0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single-word frame
    words[0] = 32'h12345678;
    d0 = done_seen; e0 = err_seen; w0 = wr_seen;
    send_frame(1, 1'b0);
    idle(3);
    expect_outcome("one_word", d0, e0, w0, 1, 0, 1, 1'b1, 6'd1);

    // Two words, wrong checksum; 0xA5 bytes in payload are plain data
    words[0] = 32'hDEADBEEF;
    words[1] = 32'h0000A5A5;
    d0 = done_seen; e0 = err_seen; w0 = wr_seen;
    send_frame(2, 1'b1);
    idle(3);
    expect_outcome("bad_csum", d0, e0, w0, 0, 1, 2, 1'b0, 6'd1);

    // Illegal lengths
    d0 = done_seen; e0 = err_seen; w0 = wr_seen;
    send(8'hA5); send(8'h00);
    idle(3);
    expect_outcome("len_zero", d0, e0, w0, 0, 1, 0, 1'b0, 6'd1);
    d0 = done_seen; e0 = err_seen; w0 = wr_seen;
    send(8'hA5); send(8'h21);
    idle(3);
    expect_outcome("len_33", d0, e0, w0, 0, 1, 0, 1'b0, 6'd1);

    // Inter-byte timeout, then recovery
    e0 = err_seen;
    send(8'hA5); send(8'h01); send(8'h12);
    idle(10);
    check("timeout_early_err", 64'(err_seen - e0), 64'(0));
    check("timeout_early_busy", 64'(bus.busy), 64'(1));
    idle(10);
    check("timeout_err", 64'(err_seen - e0), 64'(1));
    check("timeout_busy", 64'(bus.busy), 64'(0));
    words[0] = 32'hCAFEF00D;
    d0 = done_seen; e0 = err_seen; w0 = wr_seen;
    send_frame(1, 1'b0);
    idle(3);
    expect_outcome("after_timeout", d0, e0, w0, 1, 0, 1, 1'b1, 6'd1);

    // Leading junk, then a full 32-word frame back-to-back
    for (int i = 0; i < N; i++) words[i] = $urandom;
    words[5] = 32'hA5A5A5A5;
    d0 = done_seen; e0 = err_seen; w0 = wr_seen;
    send(8'h00); send(8'hFF); send(8'h5A);
    send_frame(N, 1'b0);
    idle(3);
    expect_outcome("full_bank", d0, e0, w0, 1, 0, N, 1'b1, 6'd32);

    // Reset mid-frame: no pulse, outputs return to reset values
    e0 = err_seen; d0 = done_seen;
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h33);
    @(negedge clk);
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    idle(2);
    check("mid_reset_no_err", 64'(err_seen - e0), 64'(0));
    check("mid_reset_no_done", 64'(done_seen - d0), 64'(0));
    words[0] = 32'h0BADF00D;
    d0 = done_seen; e0 = err_seen; w0 = wr_seen;
    send_frame(1, 1'b0);
    idle(3);
    expect_outcome("after_reset", d0, e0, w0, 1, 0, 1, 1'b1, 6'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
